// File: rtl/ansi_terminal_decoder.sv
// Byte-stream ANSI decoder: prints text and applies a small CSI subset (CUP, SGR, ED 2J),
// emitting GPU-format VRAM cell writes and yielding the bus whenever the GPU holds VRAM_LOCK.
module ansi_terminal_decoder #(
    parameter int MAX_PARAMS = 6,
    parameter int PARAM_SAT  = 99
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic        VRAM_LOCK,
    output logic        VRAM_ENABLE,
    output logic        VRAM_WRITE,
    output logic [10:0] VRAM_ADDR,
    output logic [15:0] VRAM_DATA_W,
    output logic        BUSY,
    output logic        OVERRUN
);
    localparam int CW = $clog2(MAX_PARAMS + 1);
    localparam int PW = $clog2(PARAM_SAT + 1);
    localparam logic [CW-1:0] MAXP  = CW'(MAX_PARAMS);
    localparam logic [CW-1:0] LASTP = CW'(MAX_PARAMS - 1);
    localparam logic [PW+3:0] SAT   = (PW+4)'(PARAM_SAT);

    localparam logic [2:0] ST_GROUND = 3'd0;
    localparam logic [2:0] ST_ESC    = 3'd1;
    localparam logic [2:0] ST_CSI    = 3'd2;
    localparam logic [2:0] ST_SGR    = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;
    localparam logic [2:0] ST_WRITE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [4:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic [2:0]    fg_q, fg_d, bg_q, bg_d;
    logic          bold_q, bold_d, ul_q, ul_d, priv_q, priv_d, ovr_q, ovr_d;
    logic [7:0]    char_q, char_d;
    logic [PW-1:0] cur_q, cur_d, sgr_p;
    logic [PW-1:0] param_q [MAX_PARAMS];
    logic [PW-1:0] param_d [MAX_PARAMS];
    logic [PW-1:0] fin     [MAX_PARAMS];
    logic [CW-1:0] count_q, count_d, idx_q, idx_d, last_q, last_d;
    logic [10:0]   clr_q, clr_d;
    logic          busy, we;

    function automatic logic [PW-1:0] sat_param(input logic [PW-1:0] cur, input logic [3:0] dig);
        logic [PW+3:0] acc;
        acc = (PW+4)'(cur) * (PW+4)'(10) + (PW+4)'(dig);
        return (acc > SAT) ? PW'(PARAM_SAT) : acc[PW-1:0];
    endfunction

    // Maps a 1-based CUP parameter onto a 0-based coordinate; 0 means "default to 1".
    function automatic logic [7:0] clamp_pos(input logic [PW-1:0] p, input logic [7:0] lim);
        logic [7:0] pe;
        pe = 8'(p);
        if (pe == 8'd0) return 8'd0;
        if (pe > lim)   return lim - 8'd1;
        return pe - 8'd1;
    endfunction

    assign busy  = (state_q == ST_SGR) || (state_q == ST_CLEAR) || (state_q == ST_WRITE);
    assign we    = ((state_q == ST_WRITE) || (state_q == ST_CLEAR)) && !VRAM_LOCK;
    assign sgr_p = param_q[idx_q];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        bold_d  = bold_q;
        ul_d    = ul_q;
        priv_d  = priv_q;
        char_d  = char_q;
        cur_d   = cur_q;
        param_d = param_q;
        count_d = count_q;
        idx_d   = idx_q;
        last_d  = last_q;
        clr_d   = clr_q;
        ovr_d   = ovr_q | (RX_VALID & busy);

        // Parameter list as it will look once the final byte's pending value is stored.
        fin = param_q;
        if (count_q < MAXP) fin[count_q] = cur_q;

        case (state_q)
            ST_GROUND: if (RX_VALID) begin
                if (RX_DATA == 8'h1B) begin
                    state_d = ST_ESC;
                end else if (RX_DATA >= 8'h20 && RX_DATA <= 8'h7E) begin
                    char_d  = RX_DATA;
                    state_d = ST_WRITE;
                end else if (RX_DATA == 8'h0D) begin
                    col_d = '0;
                end else if (RX_DATA == 8'h0A) begin
                    row_d = row_q + 5'd1;
                end
            end
            ST_ESC: if (RX_VALID) begin
                if (RX_DATA == 8'h5B) begin
                    state_d = ST_CSI;
                    cur_d   = '0;
                    count_d = '0;
                    priv_d  = 1'b0;
                    for (int i = 0; i < MAX_PARAMS; i++) param_d[i] = '0;
                end else if (RX_DATA != 8'h1B) begin
                    state_d = ST_GROUND;
                end
            end
            ST_CSI: if (RX_VALID) begin
                if (RX_DATA >= 8'h30 && RX_DATA <= 8'h39) begin
                    cur_d = sat_param(cur_q, RX_DATA[3:0]);
                end else if (RX_DATA == 8'h3B) begin
                    if (count_q < MAXP) begin
                        param_d[count_q] = cur_q;
                        count_d          = count_q + CW'(1);
                    end
                    cur_d = '0;
                end else if (RX_DATA == 8'h3F) begin
                    priv_d = 1'b1;
                end else if (RX_DATA == 8'h1B) begin
                    state_d = ST_ESC;
                end else if (RX_DATA >= 8'h40 && RX_DATA <= 8'h7E) begin
                    param_d = fin;
                    state_d = ST_GROUND;
                    if (!priv_q) begin
                        if (RX_DATA == 8'h48 || RX_DATA == 8'h66) begin
                            row_d = 5'(clamp_pos(fin[0], 8'd32));
                            col_d = 6'(clamp_pos(fin[1], 8'd64));
                        end else if (RX_DATA == 8'h6D) begin
                            state_d = ST_SGR;
                            idx_d   = '0;
                            last_d  = (count_q < MAXP) ? count_q : LASTP;
                        end else if (RX_DATA == 8'h4A && fin[0] == PW'(2)) begin
                            state_d = ST_CLEAR;
                            clr_d   = '0;
                        end
                    end
                end
            end
            ST_SGR: begin
                if (sgr_p == '0) begin
                    fg_d   = 3'd7;
                    bg_d   = 3'd0;
                    bold_d = 1'b0;
                    ul_d   = 1'b0;
                end else if (sgr_p == PW'(1)) begin
                    bold_d = 1'b1;
                end else if (sgr_p == PW'(4)) begin
                    ul_d = 1'b1;
                end else if (sgr_p >= PW'(30) && sgr_p <= PW'(37)) begin
                    fg_d = 3'(sgr_p - PW'(30));
                end else if (sgr_p >= PW'(40) && sgr_p <= PW'(47)) begin
                    bg_d = 3'(sgr_p - PW'(40));
                end
                if (idx_q == last_q) state_d = ST_GROUND;
                else                 idx_d   = idx_q + CW'(1);
            end
            ST_CLEAR: if (!VRAM_LOCK) begin
                clr_d = clr_q + 11'd1;
                if (clr_q == 11'h7FF) state_d = ST_GROUND;
            end
            ST_WRITE: if (!VRAM_LOCK) begin
                // Row/col concatenate to the linear address, so carry gives both wrap rules.
                {row_d, col_d} = {row_q, col_q} + 11'd1;
                state_d        = ST_GROUND;
            end
            default: state_d = ST_GROUND;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_GROUND;
            row_q   <= '0;
            col_q   <= '0;
            fg_q    <= 3'd7;
            bg_q    <= 3'd0;
            bold_q  <= 1'b0;
            ul_q    <= 1'b0;
            priv_q  <= 1'b0;
            ovr_q   <= 1'b0;
            char_q  <= '0;
            cur_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            clr_q   <= '0;
            for (int i = 0; i < MAX_PARAMS; i++) param_q[i] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            bold_q  <= bold_d;
            ul_q    <= ul_d;
            priv_q  <= priv_d;
            ovr_q   <= ovr_d;
            char_q  <= char_d;
            cur_q   <= cur_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            clr_q   <= clr_d;
            param_q <= param_d;
        end
    end

    assign VRAM_ENABLE = we;
    assign VRAM_WRITE  = we;
    assign VRAM_ADDR   = !we ? 11'd0 : (state_q == ST_CLEAR) ? clr_q : {row_q, col_q};
    assign VRAM_DATA_W = (we && state_q == ST_WRITE) ? {bold_q, ul_q, fg_q, bg_q, char_q} : 16'h0000;
    assign BUSY        = busy;
    assign OVERRUN     = ovr_q;
endmodule

// File: tb/tb_ansi_terminal_decoder.sv
// Scoreboard bench for ansi_terminal_decoder: a sequence-level reference model predicts every
// VRAM write; a negedge monitor pops and compares each write the DUT issues.
module tb_ansi_terminal_decoder;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        VRAM_LOCK = 1'b0;
    logic        VRAM_ENABLE, VRAM_WRITE, BUSY, OVERRUN;
    logic [10:0] VRAM_ADDR;
    logic [15:0] VRAM_DATA_W;

    ansi_terminal_decoder dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .VRAM_LOCK(VRAM_LOCK), .VRAM_ENABLE(VRAM_ENABLE), .VRAM_WRITE(VRAM_WRITE),
        .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA_W(VRAM_DATA_W), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [10:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    logic [10:0] last_addr = '0;
    logic [15:0] last_data = '0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: text mode, post-ESC, or collecting a CSI body interpreted on its final byte.
    int         m_mode, m_row, m_col;
    logic [2:0] m_fg, m_bg;
    logic       m_bold, m_ul;
    logic [7:0] m_seq[$];

    function automatic void model_reset();
        m_mode = 0; m_row = 1; m_col = 1;
        m_fg = 3'd7; m_bg = 3'd0; m_bold = 1'b0; m_ul = 1'b0;
        m_seq.delete();
    endfunction

    function automatic void model_put(input logic [7:0] ch);
        wr_t w;
        w.addr = 11'((m_row - 1) * 64 + (m_col - 1));
        w.data = {m_bold, m_ul, m_fg, m_bg, ch};
        exp_q.push_back(w);
        m_col++;
        if (m_col > 64) begin m_col = 1; m_row++; end
        if (m_row > 32) m_row = 1;
    endfunction

    function automatic void model_csi(input logic [7:0] fb);
        int ps[$];
        int cur;
        bit priv;
        wr_t w;
        cur = 0; priv = 0;
        foreach (m_seq[i]) begin
            if (m_seq[i] >= "0" && m_seq[i] <= "9") begin
                cur = cur * 10 + int'(m_seq[i]) - 48;
                if (cur > 99) cur = 99;
            end else if (m_seq[i] == ";") begin
                ps.push_back(cur); cur = 0;
            end else if (m_seq[i] == "?") priv = 1;
        end
        ps.push_back(cur);
        while (ps.size() > 6) void'(ps.pop_back());
        if (priv) return;
        if (fb == "H" || fb == "f") begin
            int p1;
            p1 = (ps.size() > 1) ? ps[1] : 0;
            m_row = (ps[0] == 0) ? 1 : (ps[0] > 32 ? 32 : ps[0]);
            m_col = (p1 == 0) ? 1 : (p1 > 64 ? 64 : p1);
        end else if (fb == "m") begin
            foreach (ps[i]) begin
                if (ps[i] == 0) begin m_fg = 3'd7; m_bg = 3'd0; m_bold = 1'b0; m_ul = 1'b0; end
                else if (ps[i] == 1) m_bold = 1'b1;
                else if (ps[i] == 4) m_ul = 1'b1;
                else if (ps[i] >= 30 && ps[i] <= 37) m_fg = 3'(ps[i] - 30);
                else if (ps[i] >= 40 && ps[i] <= 47) m_bg = 3'(ps[i] - 40);
            end
        end else if (fb == "J" && ps[0] == 2) begin
            for (int a = 0; a < 2048; a++) begin
                w.addr = 11'(a); w.data = 16'h0000;
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        case (m_mode)
            0: begin
                if (b == 8'h1B) m_mode = 1;
                else if (b >= 8'h20 && b <= 8'h7E) model_put(b);
                else if (b == 8'h0D) m_col = 1;
                else if (b == 8'h0A) m_row = (m_row == 32) ? 1 : m_row + 1;
            end
            1: begin
                if (b == "[") begin m_mode = 2; m_seq.delete(); end
                else if (b != 8'h1B) m_mode = 0;
            end
            default: begin
                if (b == 8'h1B) m_mode = 1;
                else if (b >= 8'h40 && b <= 8'h7E) begin model_csi(b); m_mode = 0; end
                else m_seq.push_back(b);
            end
        endcase
    endfunction

    // Monitor: every DUT write must match the head of the expected queue.
    always @(negedge CLK) begin
        wr_t e;
        if (VRAM_ENABLE) begin
            n_wr++;
            last_addr = VRAM_ADDR;
            last_data = VRAM_DATA_W;
            check("wr_strobe", 32'(VRAM_WRITE), 32'd1);
            check("wr_while_locked", 32'(VRAM_LOCK), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", VRAM_ADDR, VRAM_DATA_W);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(VRAM_ADDR), 32'(e.addr));
                check("wr_data", 32'(VRAM_DATA_W), 32'(e.data));
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (BUSY && k < 5000) begin tick(); k++; end
        if (BUSY) begin
            n_vec++; n_bad++;
            $display("FAIL idle_timeout: got BUSY=1 after %0d cycles, expected 0", k);
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        RX_DATA = b; RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int lk);
        VRAM_LOCK = (lk > 0);
        pulse(b);
        model_byte(b);
        for (int i = 0; i < lk; i++) tick();
        VRAM_LOCK = 1'b0;
        wait_idle();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 0);
    endtask

    task automatic esc(input string s);
        send(8'h1B, 0);
        send_str(s);
    endtask

    task automatic do_reset();
        check("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        RX_VALID = 1'b0; VRAM_LOCK = 1'b0; RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic rand_sgr_or_cup();
        string s = "";
        int n, v;
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 4);
                1: v = $urandom_range(30, 37);
                2: v = $urandom_range(40, 47);
                default: v = $urandom_range(0, 300);
            endcase
            if (i > 0) s = {s, ";"};
            s = {s, $sformatf("%0d", v)};
        end
        case ($urandom_range(0, 2))
            0: s = {s, "m"};
            1: s = {s, "H"};
            default: s = {s, "f"};
        endcase
        esc({"[", s});
    endtask

    logic [7:0] pool [20] = '{8'h41, 8'h7A, 8'h20, 8'h7E, 8'h1B, 8'h5B, 8'h30, 8'h31, 8'h39, 8'h3B,
                              8'h3F, 8'h6D, 8'h48, 8'h66, 8'h4A, 8'h0D, 8'h0A, 8'h7F, 8'h00, 8'h6C};

    initial begin
        int w0;
        model_reset();
        tick();
        check("rst_enable", 32'(VRAM_ENABLE), 32'd0);
        check("rst_write", 32'(VRAM_WRITE), 32'd0);
        check("rst_addr", 32'(VRAM_ADDR), 32'd0);
        check("rst_data", 32'(VRAM_DATA_W), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);
        tick();
        RESET = 1'b0;

        // Printable text, including the one-cycle latency to the write.
        pulse("A"); model_byte("A");
        check("lat_enable", 32'(VRAM_ENABLE), 32'd1);
        check("a_addr", 32'(VRAM_ADDR), 32'd0);
        check("a_data", 32'(VRAM_DATA_W), 32'h3841);
        wait_idle();
        send("B", 0);
        check("b_addr", 32'(last_addr), 32'd1);
        check("b_data", 32'(last_data), 32'h3842);

        esc("[5;10H"); send("x", 0);
        check("cup_addr", 32'(last_addr), 32'd265);
        check("cup_data", 32'(last_data), 32'h3878);
        esc("[0;0H"); send("y", 0);
        check("cup0_addr", 32'(last_addr), 32'd0);

        esc("[0;1;4;32;41m"); send("z", 0);
        check("sgr_data", 32'(last_data), 32'hD17A);
        esc("[m"); send("z", 0);
        check("sgr_empty_data", 32'(last_data), 32'h387A);

        esc("[32;64H"); send("q", 0);
        check("corner_addr", 32'(last_addr), 32'd2047);
        send("r", 0);
        check("wrap_addr", 32'(last_addr), 32'd0);
        esc("[99;99H"); send("s", 0);
        check("clamp_addr", 32'(last_addr), 32'd2047);
        esc("[32;5H"); send(8'h0A, 0); send("t", 0);
        check("lf_wrap_addr", 32'(last_addr), 32'd4);
        send(8'h0D, 0); send("u", 0);
        check("cr_addr", 32'(last_addr), 32'd0);

        // Full clear with a lock window and a byte dropped mid-sweep.
        w0 = n_wr;
        esc("[2");
        pulse("J"); model_byte("J");
        repeat (300) tick();
        check("clear_busy", 32'(BUSY), 32'd1);
        pulse("Q");
        check("overrun_set", 32'(OVERRUN), 32'd1);
        VRAM_LOCK = 1'b1;
        repeat (100) tick();
        VRAM_LOCK = 1'b0;
        wait_idle();
        check("clear_count", 32'(n_wr - w0), 32'd2048);
        send("v", 0);
        check("cursor_kept_addr", 32'(last_addr), 32'd1);
        check("overrun_sticky", 32'(OVERRUN), 32'd1);

        // Private and aborted sequences produce nothing; then reset aborts a locked write.
        do_reset();
        w0 = n_wr;
        esc("[?25l"); send(8'h1B, 0); send("x", 0); send("k", 0);
        check("seq_write_count", 32'(n_wr - w0), 32'd1);
        check("k_addr", 32'(last_addr), 32'd0);
        w0 = n_wr;
        VRAM_LOCK = 1'b1;
        pulse("w");
        repeat (3) tick();
        check("locked_no_enable", 32'(VRAM_ENABLE), 32'd0);
        check("locked_busy", 32'(BUSY), 32'd1);
        RESET = 1'b1; #1;
        check("abort_enable", 32'(VRAM_ENABLE), 32'd0);
        check("abort_addr", 32'(VRAM_ADDR), 32'd0);
        check("abort_data", 32'(VRAM_DATA_W), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        tick();
        RESET = 1'b0; VRAM_LOCK = 1'b0;
        model_reset();
        repeat (3) tick();
        check("abort_no_write", 32'(n_wr - w0), 32'd0);

        // Randomised byte soup and structured SGR/CUP sequences under random lock holds.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 2) == 0) rand_sgr_or_cup();
            else begin
                for (int j = 0; j < 6; j++) begin
                    if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), 0);
                    else send(pool[$urandom_range(0, 19)], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
                end
            end
            if ($urandom_range(0, 3) == 0) send(8'($urandom_range(8'h20, 8'h7E)), 0);
        end
        repeat (4) tick();
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
